mac_operand_sequencer: RTL and testbench
========================================

MAC_OPERAND_SEQUENCER -- requirements
Module: mac_operand_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, operand width (signed).
REQ-002 Parameter ACC_WIDTH, default 32, accumulator/result width (signed).
REQ-003 Parameter DEPTH, default 16, operand-pair buffer entries; LW = $clog2(DEPTH+1), AW = $clog2(DEPTH).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 wr_en  input  1  write operand pair into buffer.
REQ-007 wr_addr  input  AW  buffer write index.
REQ-008 wr_a, wr_b  input  DATA_WIDTH each  signed operand pair to store.
REQ-009 start  input  1  begin dot-product run; sampled only in IDLE.
REQ-010 vec_len  input  LW  pairs to process, sampled with start.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse, run complete.
REQ-013 dot_result  output  ACC_WIDTH  signed result of last run, held until next done.
REQ-014 mac_multiplier, mac_multiplicand  output  DATA_WIDTH each  operands driven to MAC unit.
REQ-015 mac_valid, mac_clear  output  1 each  MAC accumulate enable / accumulator clear.
REQ-016 mac_result  input  ACC_WIDTH  registered MAC accumulator; updates one edge after mac_valid.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 Buffer: DEPTH x (2*DATA_WIDTH) registers, written when wr_en=1 and FSM in IDLE; wr_en outside IDLE SHALL be ignored.
REQ-019 FSM states: IDLE, CLEAR, ISSUE, DRAIN, FINISH.
REQ-020 IDLE: start=1 and vec_len>0 -> CLEAR, latching len = min(vec_len, DEPTH) and idx=0; start=1 and vec_len=0 -> FINISH with zero-length flag set; else stay.
REQ-021 CLEAR (1 cycle): mac_clear=1, mac_valid=1, operands 0 -> ISSUE.
REQ-022 ISSUE (len cycles): mac_clear=0, mac_valid=1, operands = buffer[idx], idx increments each cycle; after idx=len-1 -> DRAIN.
REQ-023 DRAIN (1 cycle): mac_valid=0, mac_clear=0, operands 0 -> FINISH.
REQ-024 FINISH (1 cycle): dot_result <= mac_result (or 0 if zero-length flag), done=1 -> IDLE.
REQ-025 Latency: start sampled at edge E0, done high in cycle after edge E(len+2); zero-length run: done in cycle after E1 with no mac_valid/mac_clear pulses.
REQ-026 start while busy SHALL be ignored; start in the same cycle as done-return to IDLE is accepted next cycle only.
REQ-027 No arithmetic in block; dot_result SHALL equal mac_result bit-for-bit (wraps mod 2^ACC_WIDTH as MAC does).
REQ-028 mac_valid and mac_clear SHALL be 0 in IDLE, DRAIN, FINISH.

Reset
REQ-029 reset_n=0 SHALL immediately force FSM to IDLE; busy, done, mac_valid, mac_clear, operands, dot_result, idx, len all 0.
REQ-030 Buffer contents SHALL NOT be reset; reset mid-run aborts run, no done pulse.
REQ-031 After reset_n deasserts, next start SHALL run normally.

Verification
REQ-032 Write (10,20),(-15,25),(5,-8) at addr 0-2, start vec_len=3 -> mac_clear pulse, 3 mac_valid cycles, done 5 edges after start, dot_result=-215.
REQ-033 Then write (-30,-2) at addr 0, start vec_len=1 -> dot_result=60 (prior sum cleared), done 3 edges after start.
REQ-034 start vec_len=0 -> done next cycle, dot_result=0, mac_valid/mac_clear never asserted.
REQ-035 Fill all 16 entries with (-32768,-32768), start vec_len=16 -> dot_result=0 (2^34 wraps); vec_len=20 -> same, len clamped to 16.
REQ-036 Assert reset_n=0 during ISSUE -> all outputs 0 asynchronously, no done; rerun REQ-032 -> -215.
REQ-037 start and wr_en pulsed while busy -> ignored; buffer and result unchanged.

Source files
------------

// File: rtl/mac_operand_sequencer.sv
// Dot-product operand sequencer: streams a buffered list of signed operand pairs
// into an external MAC unit and captures the accumulated result.
module mac_operand_sequencer #(
    parameter  int DATA_WIDTH = 16,
    parameter  int ACC_WIDTH  = 32,
    parameter  int DEPTH      = 16,
    localparam int LW         = $clog2(DEPTH + 1),
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_a,
    input  logic [DATA_WIDTH-1:0] wr_b,
    input  logic                  start,
    input  logic [LW-1:0]         vec_len,
    output logic                  busy,
    output logic                  done,
    output logic [ACC_WIDTH-1:0]  dot_result,
    output logic [DATA_WIDTH-1:0] mac_multiplier,
    output logic [DATA_WIDTH-1:0] mac_multiplicand,
    output logic                  mac_valid,
    output logic                  mac_clear,
    input  logic [ACC_WIDTH-1:0]  mac_result
);

    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, FINISH} state_t;

    state_t                state;
    logic [LW-1:0]         idx;
    logic [LW-1:0]         len;
    logic                  zero_len;
    logic [DATA_WIDTH-1:0] mem_a [DEPTH];
    logic [DATA_WIDTH-1:0] mem_b [DEPTH];

    // Operand storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE) begin
            mem_a[wr_addr] <= wr_a;
            mem_b[wr_addr] <= wr_b;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            idx              <= '0;
            len              <= '0;
            zero_len         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            dot_result       <= '0;
            mac_multiplier   <= '0;
            mac_multiplicand <= '0;
            mac_valid        <= 1'b0;
            mac_clear        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (vec_len == '0) begin
                            zero_len <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            len              <= (vec_len > LW'(DEPTH)) ? LW'(DEPTH) : vec_len;
                            idx              <= '0;
                            mac_clear        <= 1'b1;
                            mac_valid        <= 1'b1;
                            mac_multiplier   <= '0;
                            mac_multiplicand <= '0;
                            state            <= CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    mac_clear        <= 1'b0;
                    mac_valid        <= 1'b1;
                    mac_multiplier   <= mem_a[idx[AW-1:0]];
                    mac_multiplicand <= mem_b[idx[AW-1:0]];
                    idx              <= idx + 1'b1;
                    state            <= ISSUE;
                end
                // idx runs one ahead of the pair on the bus; reaching len means the last pair is out.
                ISSUE: begin
                    if (idx == len) begin
                        mac_valid        <= 1'b0;
                        mac_multiplier   <= '0;
                        mac_multiplicand <= '0;
                        state            <= DRAIN;
                    end else begin
                        mac_multiplier   <= mem_a[idx[AW-1:0]];
                        mac_multiplicand <= mem_b[idx[AW-1:0]];
                        idx              <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    dot_result <= mac_result;
                    done       <= 1'b1;
                    state      <= FINISH;
                end
                FINISH: begin
                    // A zero-length run spends one extra FINISH cycle so done lands a cycle after start.
                    if (zero_len) begin
                        zero_len   <= 1'b0;
                        dot_result <= '0;
                        done       <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed + randomized bench for mac_operand_sequencer with a behavioural MAC
// and a shadow-buffer dot-product reference.
module tb_mac_operand_sequencer;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               wr_en;
    logic [3:0]         wr_addr;
    logic signed [15:0] wr_a, wr_b;
    logic               start;
    logic [4:0]         vec_len;
    logic               busy, done, mac_valid, mac_clear;
    logic signed [31:0] dot_result;
    logic signed [15:0] mac_multiplier, mac_multiplicand;
    logic signed [31:0] mac_result;

    int n_cmp = 0;
    int n_err = 0;
    logic signed [15:0] sh_a [16];
    logic signed [15:0] sh_b [16];

    mac_operand_sequencer #(.DATA_WIDTH(16), .ACC_WIDTH(32), .DEPTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_a(wr_a), .wr_b(wr_b), .start(start), .vec_len(vec_len),
        .busy(busy), .done(done), .dot_result(dot_result),
        .mac_multiplier(mac_multiplier), .mac_multiplicand(mac_multiplicand),
        .mac_valid(mac_valid), .mac_clear(mac_clear), .mac_result(mac_result)
    );

    always #5 clk = ~clk;

    // Behavioural MAC unit: registered accumulator, wraps at 32 bits.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            mac_result <= '0;
        else if (mac_valid)
            mac_result <= mac_clear ? 32'sd0 : mac_result + mac_multiplier * mac_multiplicand;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint ref_dot(input int vl);
        longint s = 0;
        logic signed [31:0] w;
        int n = (vl > 16) ? 16 : vl;
        for (int i = 0; i < n; i++)
            s += longint'(sh_a[i]) * longint'(sh_b[i]);
        w = s[31:0];
        return longint'(w);
    endfunction

    task automatic wr(input int addr, input int a, input int b);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'(addr); wr_a = 16'(a); wr_b = 16'(b);
        @(negedge clk);
        wr_en = 1'b0;
        sh_a[addr] = 16'(a);
        sh_b[addr] = 16'(b);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_done"}, longint'(done), 0);
        chk({tag, "_valid"}, longint'(mac_valid), 0);
        chk({tag, "_clear"}, longint'(mac_clear), 0);
        chk({tag, "_mult"}, longint'(mac_multiplier), 0);
        chk({tag, "_mcand"}, longint'(mac_multiplicand), 0);
        chk({tag, "_dot"}, longint'(dot_result), 0);
    endtask

    // One run: checks latency, MAC pulse counts, per-cycle operands and result.
    task automatic run(input string tag, input int vl, input bit poke);
        int n = 0, nvalid = 0, nclear = 0, k = 0, len;
        bit seen = 0;
        longint exp_dot;
        len = (vl > 16) ? 16 : vl;
        exp_dot = ref_dot(vl);
        @(negedge clk);
        start = 1'b1; vec_len = 5'(vl);
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy"}, longint'(busy), 1);
        while (n < 60 && !seen) begin
            if (mac_valid) begin
                nvalid++;
                if (mac_clear) nclear++;
                else if (k < 16) begin
                    chk({tag, "_opa"}, longint'(mac_multiplier), longint'(sh_a[k]));
                    chk({tag, "_opb"}, longint'(mac_multiplicand), longint'(sh_b[k]));
                    k++;
                end
            end
            if (poke && n == 2) begin
                start = 1'b1; vec_len = 5'd5;
                wr_en = 1'b1; wr_addr = 4'd0; wr_a = 16'sd7; wr_b = 16'sd7;
            end
            @(posedge clk); #1;
            start = 1'b0; wr_en = 1'b0;
            n++;
            seen = done;
        end
        chk({tag, "_latency"}, seen ? n : -1, (len == 0) ? 1 : len + 2);
        chk({tag, "_nvalid"}, nvalid, (len == 0) ? 0 : len + 1);
        chk({tag, "_nclear"}, nclear, (len == 0) ? 0 : 1);
        chk({tag, "_dot"}, longint'(dot_result), exp_dot);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, longint'(done), 0);
        chk({tag, "_idle"}, longint'(busy), 0);
        chk({tag, "_hold"}, longint'(dot_result), exp_dot);
    endtask

    initial begin
        int ones;
        reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0;
        start = 1'b0; vec_len = '0;
        for (int i = 0; i < 16; i++) begin sh_a[i] = '0; sh_b[i] = '0; end
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk) reset_n = 1'b1;
        for (int i = 0; i < 16; i++) wr(i, 0, 0);

        wr(0, 10, 20); wr(1, -15, 25); wr(2, 5, -8);
        run("basic3", 3, 0);
        chk("basic3_const", longint'(dot_result), -215);

        wr(0, -30, -2);
        run("len1", 1, 0);
        chk("len1_const", longint'(dot_result), 60);

        run("zero", 0, 0);

        for (int i = 0; i < 16; i++) wr(i, -32768, -32768);
        run("full16", 16, 0);
        chk("full16_const", longint'(dot_result), 0);
        run("clamp20", 20, 0);

        // Abort a run mid-ISSUE with an asynchronous reset.
        wr(0, 10, 20); wr(1, -15, 25); wr(2, 5, -8);
        @(negedge clk); start = 1'b1; vec_len = 5'd3;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("async_rst");
        ones = 0;
        repeat (3) begin @(posedge clk); #1 if (done) ones++; end
        chk("async_rst_nodone", ones, 0);
        @(negedge clk) reset_n = 1'b1;
        run("rerun", 3, 0);
        chk("rerun_const", longint'(dot_result), -215);

        // start/wr_en while busy must be ignored.
        run("poke", 3, 1);
        ones = 0;
        repeat (4) begin @(posedge clk); #1 if (busy || done) ones++; end
        chk("poke_no_rerun", ones, 0);
        run("poke_buf", 3, 0);
        chk("poke_buf_const", longint'(dot_result), -215);

        for (int r = 0; r < 8; r++) begin
            int nw = $urandom_range(1, 16);
            for (int i = 0; i < nw; i++)
                wr($urandom_range(0, 15), int'($urandom) % 65536 - 32768, int'($urandom) % 65536 - 32768);
            run($sformatf("rand%0d", r), $urandom_range(0, 20), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
